// File: rtl/reaction_controller.sv
//==============================================================================
// Module      : reaction_controller
// Description : Top-level sequencer for the reaction-timer game. A start press
//               clears the external ms timer, waits DELAY_MS, lights the GO
//               LED and runs the timer until the react press. It captures the
//               result, tracks the session best, and flags false starts
//               (press during the delay) and timeouts (no press in time).
// Ports       : clk_1ms      - 1 ms tick clock
//               reset        - async active-high reset, clears everything
//               btn_start    - synchronised start button level
//               btn_react    - synchronised react button level
//               time_elapsed - current count of the external timer
//               timer_clr    - one-cycle clear pulse to the timer
//               timer_start  - run enable to the timer
//               timer_stop   - stop/freeze request to the timer
//               led_go       - GO indicator
//               result       - last valid reaction time (ms)
//               result_valid - high while a fresh result is shown
//               best         - session minimum, all-ones means none yet
//               false_start  - high after a press during the delay
//               timeout      - high after no press within TIMEOUT_MS
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module reaction_controller #(
  parameter int DELAY_MS   = 2000,
  parameter int TIMEOUT_MS = 9999,
  parameter int TW         = 24
) (
  input  logic          clk_1ms,
  input  logic          reset,
  input  logic          btn_start,
  input  logic          btn_react,
  input  logic [TW-1:0] time_elapsed,
  output logic          timer_clr,
  output logic          timer_start,
  output logic          timer_stop,
  output logic          led_go,
  output logic [TW-1:0] result,
  output logic          result_valid,
  output logic [TW-1:0] best,
  output logic          false_start,
  output logic          timeout
);

  localparam int          DW           = $clog2(DELAY_MS);
  localparam logic [DW-1:0] DELAY_LAST   = DW'(DELAY_MS - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_MS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    GO   = 3'd2,
    DONE = 3'd3,
    FOUL = 3'd4,
    TMO  = 3'd5
  } state_t;

  state_t          state, state_d;
  logic            btn_start_q;
  logic [DW-1:0]   delay_cnt, delay_cnt_d;
  logic            timer_clr_d, timer_start_d, timer_stop_d, led_go_d;
  logic [TW-1:0]   result_d, best_d;
  logic            result_valid_d, false_start_d, timeout_d;
  logic            start_edge;

  assign start_edge = btn_start & ~btn_start_q;

  always_ff @(posedge clk_1ms or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      btn_start_q  <= 1'b0;
      delay_cnt    <= '0;
      timer_clr    <= 1'b0;
      timer_start  <= 1'b0;
      timer_stop   <= 1'b0;
      led_go       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      best         <= '1;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_d;
      btn_start_q  <= btn_start;
      delay_cnt    <= delay_cnt_d;
      timer_clr    <= timer_clr_d;
      timer_start  <= timer_start_d;
      timer_stop   <= timer_stop_d;
      led_go       <= led_go_d;
      result       <= result_d;
      result_valid <= result_valid_d;
      best         <= best_d;
      false_start  <= false_start_d;
      timeout      <= timeout_d;
    end
  end

  always_comb begin
    // Everything holds by default; timer_clr is a single-cycle pulse.
    state_d        = state;
    delay_cnt_d    = delay_cnt;
    timer_clr_d    = 1'b0;
    timer_start_d  = timer_start;
    timer_stop_d   = timer_stop;
    led_go_d       = led_go;
    result_d       = result;
    result_valid_d = result_valid;
    best_d         = best;
    false_start_d  = false_start;
    timeout_d      = timeout;

    case (state)
      IDLE, DONE, FOUL, TMO: begin
        if (start_edge) begin
          state_d        = ARM;
          timer_clr_d    = 1'b1;
          delay_cnt_d    = '0;
          timer_start_d  = 1'b0;
          timer_stop_d   = 1'b0;
          led_go_d       = 1'b0;
          result_valid_d = 1'b0;
          false_start_d  = 1'b0;
          timeout_d      = 1'b0;
        end
      end

      ARM: begin
        led_go_d      = 1'b0;
        timer_start_d = 1'b0;
        // A press during the delay wins even on the terminal count cycle.
        if (btn_react) begin
          state_d       = FOUL;
          false_start_d = 1'b1;
        end else if (delay_cnt == DELAY_LAST) begin
          // Counter is left at its terminal value so it never wraps.
          state_d       = GO;
          led_go_d      = 1'b1;
          timer_start_d = 1'b1;
          timer_stop_d  = 1'b0;
        end else begin
          delay_cnt_d = delay_cnt + 1'b1;
        end
      end

      GO: begin
        // A press on the same cycle as the timeout threshold still counts.
        if (btn_react) begin
          state_d        = DONE;
          result_d       = time_elapsed;
          result_valid_d = 1'b1;
          timer_start_d  = 1'b0;
          timer_stop_d   = 1'b1;
          led_go_d       = 1'b0;
          if (time_elapsed < best) begin
            best_d = time_elapsed;
          end
        end else if (time_elapsed >= TIMEOUT_LAST) begin
          state_d       = TMO;
          timeout_d     = 1'b1;
          timer_start_d = 1'b0;
          timer_stop_d  = 1'b1;
          led_go_d      = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
